// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary helper for the Gray stream monitor.
package gray_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } delta_t;

  // Zero-extended Gray input yields the same low binary bits, so one 32-bit
  // implementation serves every WIDTH up to 32.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned k = 1; k < 32; k++) begin
      b[31-k] = b[32-k] ^ g[31-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = WIDTH'(gray2bin(32'(gray)));
  end

endmodule

// File: rtl/gray_stream_monitor.sv
// Samples a Gray-coded count, converts to binary and checks each step is 0 or +/-1.
module gray_stream_monitor
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 dir,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_bin;
  logic                 r_bin_valid;
  logic                 r_dir;
  logic                 r_step_err;
  logic                 r_locked;
  logic [ERR_CNT_W-1:0] r_err;
  logic [GW-1:0]        r_good;

  logic [WIDTH-1:0]     w_bin;
  logic [WIDTH-1:0]     w_delta;
  logic [GW-1:0]        w_good_nxt;
  delta_t               w_class;

  gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
    .gray (gray_in),
    .bin  (w_bin)
  );

  // r_bin doubles as the previous sample; wrap of the subtraction gives mod 2^WIDTH.
  always_comb begin
    w_delta    = w_bin - r_bin;
    w_good_nxt = r_good + GW'(1);
    if (w_delta == '0)
      w_class = HOLD;
    else if (w_delta == WIDTH'(1))
      w_class = UP;
    else if (w_delta == '1)
      w_class = DOWN;
    else
      w_class = ILLEGAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_dir       <= 1'b0;
      r_step_err  <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= '0;
      r_good      <= '0;
    end else if (clear) begin
      r_state     <= EMPTY;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_dir       <= 1'b0;
      r_step_err  <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= '0;
      r_good      <= '0;
    end else begin
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;
      if (valid_in) begin
        r_bin       <= w_bin;
        r_bin_valid <= 1'b1;
        case (r_state)
          EMPTY: r_state <= ACQUIRE;
          ACQUIRE: begin
            if (w_class == UP || w_class == DOWN) begin
              r_dir  <= (w_class == UP);
              r_good <= w_good_nxt;
              if (w_good_nxt == GW'(LOCK_CNT)) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else if (w_class == ILLEGAL) begin
              r_step_err <= 1'b1;
              r_good     <= '0;
              if (r_err != '1) r_err <= r_err + 1'b1;
            end
          end
          LOCKED: begin
            if (w_class == UP || w_class == DOWN) begin
              r_dir <= (w_class == UP);
            end else if (w_class == ILLEGAL) begin
              r_step_err <= 1'b1;
              r_good     <= '0;
              r_locked   <= 1'b0;
              r_state    <= ACQUIRE;
              if (r_err != '1) r_err <= r_err + 1'b1;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

  assign bin_out   = r_bin;
  assign bin_valid = r_bin_valid;
  assign dir       = r_dir;
  assign step_err  = r_step_err;
  assign locked    = r_locked;
  assign err_count = r_err;

endmodule

// File: tb/tb_gray_stream_monitor.sv
// Directed self-checking bench for gray_stream_monitor (WIDTH=3, LOCK_CNT=2, ERR_CNT_W=8).
module tb_gray_stream_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       valid_in = 1'b0;
  logic [2:0] gray_in = '0;
  logic [2:0] bin_out;
  logic       bin_valid;
  logic       dir;
  logic       step_err;
  logic       locked;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  gray_stream_monitor #(.WIDTH(3), .LOCK_CNT(2), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .valid_in  (valid_in),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .dir       (dir),
    .step_err  (step_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One sample with valid_in high for a single edge; returns at the next negedge.
  task automatic send(input logic [2:0] g);
    @(negedge clk);
    valid_in = 1'b1;
    gray_in  = g;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin"},    32'(bin_out),   0);
    chk({tag, "_bv"},     32'(bin_valid), 0);
    chk({tag, "_dir"},    32'(dir),       0);
    chk({tag, "_serr"},   32'(step_err),  0);
    chk({tag, "_locked"}, 32'(locked),    0);
    chk({tag, "_errcnt"}, 32'(err_count), 0);
  endtask

  logic [2:0] up_g [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  int pulses;
  int exp_err;

  initial begin
    // Reset state
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: count up through a full wrap
    for (int i = 0; i < 9; i++) begin
      send(up_g[i]);
      chk("t1_bin", 32'(bin_out), i % 8);
      chk("t1_bv", 32'(bin_valid), 1);
      chk("t1_serr", 32'(step_err), 0);
      if (i == 1) chk("t1_notlocked", 32'(locked), 0);
      if (i == 2) chk("t1_locked", 32'(locked), 1);
    end
    chk("t1_dir", 32'(dir), 1);
    chk("t1_err", 32'(err_count), 0);
    @(negedge clk);
    chk("t1_bv_idle", 32'(bin_valid), 0);

    // 2: reverse while locked, wrapping 0 -> 7
    send(3'b100); chk("t2_bin7", 32'(bin_out), 7); chk("t2_dir", 32'(dir), 0);
    send(3'b101); chk("t2_bin6", 32'(bin_out), 6); chk("t2_serr", 32'(step_err), 0);
    send(3'b111); chk("t2_bin5", 32'(bin_out), 5);
    chk("t2_locked", 32'(locked), 1);
    chk("t2_dir_end", 32'(dir), 0);

    // 3: walk down to 0, jump to 2, reacquire
    send(3'b110); send(3'b010); send(3'b011); send(3'b001); send(3'b000);
    chk("t3_at0", 32'(bin_out), 0);
    chk("t3_lock0", 32'(locked), 1);
    send(3'b011);
    chk("t3_bin2", 32'(bin_out), 2);
    chk("t3_serr", 32'(step_err), 1);
    chk("t3_err", 32'(err_count), 1);
    chk("t3_unlock", 32'(locked), 0);
    @(negedge clk);
    chk("t3_serr_pulse", 32'(step_err), 0);
    send(3'b010); chk("t3_nolock1", 32'(locked), 0);
    send(3'b110); chk("t3_relock", 32'(locked), 1);
    send(3'b111);
    chk("t3_locked", 32'(locked), 1);
    chk("t3_dir", 32'(dir), 1);
    chk("t3_serr_after", 32'(step_err), 0);

    // 4: hold samples while locked
    send(3'b110); send(3'b010);
    chk("t4_at3", 32'(bin_out), 3);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      send(3'b010);
      if (bin_valid) pulses++;
      chk("t4_serr", 32'(step_err), 0);
    end
    chk("t4_pulses", 32'(pulses), 3);
    chk("t4_dir", 32'(dir), 0);
    chk("t4_locked", 32'(locked), 1);
    chk("t4_err", 32'(err_count), 1);

    // 5: back-to-back illegal steps saturate the error counter
    exp_err = 1;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      valid_in = 1'b1;
      gray_in  = (i % 2 == 0) ? 3'b000 : 3'b011;
      @(negedge clk);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      chk("t5_serr", 32'(step_err), 1);
      chk("t5_err", 32'(err_count), exp_err);
    end
    valid_in = 1'b0;
    chk("t5_sat", 32'(err_count), 255);
    chk("t5_bin", 32'(bin_out), 2);

    // 6: async reset between edges, then synchronous clear with a sample
    send(3'b010); send(3'b110);
    chk("t6_prelock", 32'(locked), 1);
    #2 rst = 1'b0;
    #1 chk_zero("t6_async");
    #1 rst = 1'b1;
    send(3'b101);
    chk("t6_first_bin", 32'(bin_out), 6);
    chk("t6_first_serr", 32'(step_err), 0);
    chk("t6_first_locked", 32'(locked), 0);
    chk("t6_first_err", 32'(err_count), 0);
    send(3'b100); send(3'b000);
    chk("t6_relock", 32'(locked), 1);
    chk("t6_dir", 32'(dir), 1);
    @(negedge clk);
    clear    = 1'b1;
    valid_in = 1'b1;
    gray_in  = 3'b011;
    @(negedge clk);
    clear    = 1'b0;
    valid_in = 1'b0;
    chk_zero("t6_clear");
    send(3'b001);
    chk("t6_clr_first_bin", 32'(bin_out), 1);
    chk("t6_clr_first_serr", 32'(step_err), 0);
    chk("t6_clr_first_locked", 32'(locked), 0);
    send(3'b011);
    chk("t6_clr_step", 32'(step_err), 0);
    chk("t6_clr_bin2", 32'(bin_out), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
